window_3x3_gen: RTL
===================

# window_3x3_gen

Streaming 3x3 neighbourhood generator that feeds the median filter's compare-exchange sorting network. It takes a raster-order pixel stream, one pixel per accepted cycle, and buffers the two previous image lines. It presents all nine pixels of each fully populated 3x3 window in parallel, with a valid strobe and an end-of-frame marker. Border windows that are only partially populated are never emitted.

## Interface
- IMG_WIDTH, 640: pixels per line (≥3)
- IMG_HEIGHT, 480: lines per frame (≥3)
- DATA_W, 8: pixel width in bits
- iClk  in  1  clock; all logic on rising edge
- iRst  in  1  synchronous, active-high reset
- iValid  in  1  input pixel valid; pixel accepted on any edge where iValid=1 (no backpressure)
- iSof  in  1  start of frame; qualified by iValid; marks accepted pixel as (row 0, col 0)
- iData  in  DATA_W  input pixel
- oValid  out  1  oWindow holds a new window this cycle
- oEof  out  1  high with oValid on the last window of a frame
- oWindow  out  9*DATA_W  window; element k = 3*i+j occupies bits [DATA_W*k +: DATA_W]; i = window row (0 = oldest line), j = window column (0 = oldest/leftmost); centre is k=4

## Operation
- Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) track the position of the next accepted pixel.
- On accept: col increments; at IMG_WIDTH-1 it wraps to 0 and row increments; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
- Two line buffers, each IMG_WIDTH deep, are addressed by col and are read-before-write.
  - On accept of pixel (r,c), LB1[c] is read, yielding (r-1,c), and LB2[c] is read, yielding (r-2,c).
  - Then LB2[c] is written with the old LB1[c], and LB1[c] is written with iData.
- A 3x3 register array shifts left on each accept. The new rightmost column is {(r-2,c), (r-1,c), (r,c)} for window rows 0..2.
- Emission: the accept of (r,c) with r≥2 and c≥2 produces the window covering rows r-2..r and cols c-2..c, centred on (r-1,c-1).
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows are produced per frame.
- oEof accompanies the window produced by accepting (IMG_HEIGHT-1, IMG_WIDTH-1).
- iSof with iValid: the accepted pixel is forced to position (0,0), whatever the counter values.
  - Counters continue from (0,1).
  - Line buffer contents are not cleared; stale data is never emitted, because of the r≥2 gating.
- iSof without iValid is ignored.
- Stale columns from the previous line are shifted out before c reaches 2, so no per-line flush is needed.
- Arithmetic: pure data movement. Pixel values pass bit-exact and unsigned; there is no rounding or saturation.

## Timing
- Latency: window outputs register on the edge after the accepting edge. oValid/oEof/oWindow change 1 cycle after the accepted pixel.
- oValid and oEof are single-cycle pulses per qualifying accept. Back-to-back accepts give back-to-back oValid.
- Idle cycles (iValid=0):
  - all state holds;
  - oValid=0, oEof=0;
  - oWindow holds its last value.
- Reset (iRst=1, synchronous):
  - row=0, col=0;
  - oValid=0, oEof=0, oWindow=0;
  - shift array cleared to 0;
  - line buffer RAM is not reset.
- Reset takes priority over iValid/iSof in the same cycle.
- Reset mid-frame: the frame is abandoned. The next accepted pixel is (0,0) whether or not iSof is asserted.
- iSof on the same edge as the last pixel of a frame: iSof wins. That pixel is (0,0), and no oEof is produced for the interrupted frame.

## Test plan
- IMG_WIDTH=5, IMG_HEIGHT=4, continuous iValid, iData=10*r+c, iSof on the first pixel.
  - Required: exactly 6 oValid pulses.
  - First pulse 1 cycle after pixel (2,2), with element k=3i+j = 10i+j (centre 11).
  - Last pulse has oEof=1 and centre 23.
- Same frame with iValid toggling 1,0,0,1,…
  - Required: identical window sequence and count as the continuous case.
  - oValid never asserted on idle-input cycles; oWindow stable during gaps.
- Two consecutive frames with no gap.
  - Required: 12 windows in total, and oEof exactly twice.
  - The first window of frame 2 contains only frame-2 data: centre 11 when frame-2 data equals frame-1 data plus 100, giving centre 111.
- iSof asserted at pixel (2,3) of a frame.
  - Required: the counters restart and no window is emitted for the next 2 lines plus 2 pixels.
  - The next window has its centre equal to the restarted frame's (1,1) pixel.
- iRst pulsed mid-frame at pixel (2,3).
  - Required: oValid=0 and oWindow=0 the following cycle.
  - The next accepted pixel is treated as (0,0), and the first window appears only after (2,2) of the new stream.
- IMG_WIDTH=3, IMG_HEIGHT=3, all pixels 255 except centre 0.
  - Required: exactly one window, with oValid=1 and oEof=1 together, k4=0 and the other elements 255.

Source files
------------

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift array,
// emitting only fully populated windows of a raster-order pixel stream.
module window_3x3_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    input  logic                  iSof,
    input  logic [DATA_W-1:0]     iData,
    output logic                  oValid,
    output logic                  oEof,
    output logic [9*DATA_W-1:0]   oWindow
);

    localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned WIN_W = 9 * DATA_W;

    logic [COL_W-1:0]  col_q, col_d, pos_c;
    logic [ROW_W-1:0]  row_q, row_d, pos_r;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WIN_W-1:0]  owin_q, owin_d;
    logic              valid_q, valid_d;
    logic              eof_q, eof_d;

    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] lb2 [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [DATA_W-1:0] new_col [3];

    // Position of the pixel being accepted; iSof forces it to (0,0).
    always_comb begin
        pos_c      = iSof ? '0 : col_q;
        pos_r      = iSof ? '0 : row_q;
        lb1_rd     = lb1[pos_c];
        lb2_rd     = lb2[pos_c];
        new_col[0] = lb2_rd;
        new_col[1] = lb1_rd;
        new_col[2] = iData;
    end

    // Next-state: counters, window shift and emission gating.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        owin_d  = owin_q;
        valid_d = 1'b0;
        eof_d   = 1'b0;
        if (iValid) begin
            if (pos_c == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (pos_r == ROW_W'(IMG_HEIGHT - 1)) ? '0 : pos_r + ROW_W'(1);
            end else begin
                col_d = pos_c + COL_W'(1);
                row_d = pos_r;
            end
            for (int i = 0; i < 3; i++) begin
                win_d[DATA_W*(3*i)   +: DATA_W] = win_q[DATA_W*(3*i+1) +: DATA_W];
                win_d[DATA_W*(3*i+1) +: DATA_W] = win_q[DATA_W*(3*i+2) +: DATA_W];
                win_d[DATA_W*(3*i+2) +: DATA_W] = new_col[i];
            end
            if ((pos_r >= ROW_W'(2)) && (pos_c >= COL_W'(2))) begin
                valid_d = 1'b1;
                owin_d  = win_d;
                eof_d   = (pos_r == ROW_W'(IMG_HEIGHT - 1)) &&
                          (pos_c == COL_W'(IMG_WIDTH - 1));
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            owin_q  <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            owin_q  <= owin_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
        end
    end

    // Line buffers are read-before-write and deliberately not reset.
    always_ff @(posedge iClk) begin
        if (iValid && !iRst) begin
            lb2[pos_c] <= lb1_rd;
            lb1[pos_c] <= iData;
        end
    end

    assign oValid  = valid_q;
    assign oEof    = eof_q;
    assign oWindow = owin_q;

endmodule
